// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, picks the next fetch address and loads
// the IF/ID pipe register, plus saturating fetch performance counters.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush_pc,
  input  logic                  flush_if_id,
  input  logic [ADDR_WIDTH-1:0] jump_address,
  input  logic                  take_branch,
  input  logic [ADDR_WIDTH-1:0] branch_predict,
  input  logic                  halt,
  input  logic [INSN_WIDTH-1:0] imem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  if_id_valid,
  output logic [INSN_WIDTH-1:0] if_id_instruction,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_branch_taken,
  output logic [ADDR_WIDTH-1:0] if_id_branch_taken_address,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count,
  output logic [CNT_WIDTH-1:0]  redirect_count,
  output logic [CNT_WIDTH-1:0]  predict_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  taken_q, taken_d;
  logic [ADDR_WIDTH-1:0] taken_addr_q, taken_addr_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0]  redir_cnt_q, redir_cnt_d;
  logic [CNT_WIDTH-1:0]  pred_cnt_q, pred_cnt_d;

  logic redirect;
  logic fetch_ok;

  // Next-state, next-PC, IF/ID and counter update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    insn_d       = insn_q;
    if_pc_d      = if_pc_q;
    taken_d      = taken_q;
    taken_addr_d = taken_addr_q;
    fetch_cnt_d  = fetch_cnt_q;
    redir_cnt_d  = redir_cnt_q;
    pred_cnt_d   = pred_cnt_q;

    redirect = flush_pc && (state_q != ST_BOOT);
    fetch_ok = (state_q == ST_RUN) && !halt;

    if (redirect) begin
      pc_d = jump_address;
    end else if (!stall && fetch_ok) begin
      pc_d = take_branch ? branch_predict : pc_q + ADDR_WIDTH'(1);
    end

    if (flush_if_id || (!stall && !fetch_ok)) begin
      valid_d      = 1'b0;
      insn_d       = NOP_INSN;
      if_pc_d      = '0;
      taken_d      = 1'b0;
      taken_addr_d = '0;
    end else if (!stall) begin
      valid_d      = 1'b1;
      insn_d       = imem_rdata;
      if_pc_d      = pc_q;
      taken_d      = take_branch;
      taken_addr_d = take_branch ? branch_predict : '0;
      if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(1);
      if (take_branch && (pred_cnt_q != '1)) pred_cnt_d = pred_cnt_q + CNT_WIDTH'(1);
    end

    if (redirect && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);

    // HALT may sit on a mispredicted path, so only a redirect releases it
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt && !flush_pc && !stall) state_d = ST_HALT;
      ST_HALT: if (flush_pc) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      insn_q       <= NOP_INSN;
      if_pc_q      <= '0;
      taken_q      <= 1'b0;
      taken_addr_q <= '0;
      halted_q     <= 1'b0;
      fetch_cnt_q  <= '0;
      redir_cnt_q  <= '0;
      pred_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      insn_q       <= insn_d;
      if_pc_q      <= if_pc_d;
      taken_q      <= taken_d;
      taken_addr_q <= taken_addr_d;
      halted_q     <= halted_d;
      fetch_cnt_q  <= fetch_cnt_d;
      redir_cnt_q  <= redir_cnt_d;
      pred_cnt_q   <= pred_cnt_d;
    end
  end

  assign pc                         = pc_q;
  assign if_id_valid                = valid_q;
  assign if_id_instruction          = insn_q;
  assign if_id_pc                   = if_pc_q;
  assign if_id_branch_taken         = taken_q;
  assign if_id_branch_taken_address = taken_addr_q;
  assign halted                     = halted_q;
  assign fetch_count                = fetch_cnt_q;
  assign redirect_count             = redir_cnt_q;
  assign predict_count              = pred_cnt_q;

endmodule
